// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - borrow_in, one bit per clock, LSB first.
// Ports: clk, n_rst (async active-low), start/a/b/borrow_in in; busy, done, difference,
//        borrow_out, overflow out (all registered). Optional SERIAL_SUB_ADD_MODE_EN adds add_sel.
// Latency: start accepted at edge k -> outputs and done pulse update at edge k+NUM_BITS+1.
// Backpressure: none; start is ignored while busy, and is accepted back-to-back from DONE.
module serial_subtractor #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic                add_sel,
`endif
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] difference,
    output logic                borrow_out,
    output logic                overflow
);

    localparam int CW = $clog2(NUM_BITS) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_BITS-1:0] a_sr;
    logic [NUM_BITS-1:0] b_sr;
    logic [NUM_BITS-1:0] res_sr;
    logic [CW-1:0]       cnt;
    logic                br;
    logic                a_msb;
    logic                b_msb;
    logic                add_mode;

    logic x;
    logic y;
    logic d;
    logic br_next;
    logic ovf;

    // One bit-slice; br doubles as the carry when adding.
    always_comb begin
        x = a_sr[0];
        y = b_sr[0];
        d = x ^ y ^ br;
        if (add_mode) begin
            br_next = (x & y) | (br & (x ^ y));
            ovf     = (a_msb == b_msb) && (res_sr[NUM_BITS-1] != a_msb);
        end else begin
            br_next = (~x & y) | (~(x ^ y) & br);
            ovf     = (a_msb != b_msb) && (res_sr[NUM_BITS-1] != a_msb);
        end
    end

    // add_mode is hard-wired low in the subtract-only build.
    logic add_req;
`ifdef SERIAL_SUB_ADD_MODE_EN
    assign add_req = add_sel;
`else
    assign add_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            add_mode   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        br       <= borrow_in;
                        a_msb    <= a[NUM_BITS-1];
                        b_msb    <= b[NUM_BITS-1];
                        add_mode <= add_req;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    done   <= 1'b0;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d, res_sr[NUM_BITS-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Result is published on the edge leaving DONE, so a back-to-back
                    // start reloads the shifters while the old result is captured.
                    done       <= 1'b1;
                    difference <= res_sr;
                    borrow_out <= br;
                    overflow   <= ovf;
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        br       <= borrow_in;
                        a_msb    <= a[NUM_BITS-1];
                        b_msb    <= b[NUM_BITS-1];
                        add_mode <= add_req;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
